// File: rtl/cpu_core.sv
// Minimal 8-bit accumulator CPU: multi-cycle fetch/decode/execute over a
// synchronous memory port with one-cycle read latency.
module cpu_core (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] from_memory,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic       write,
    output logic [7:0] pc_out,
    output logic [7:0] a_out,
    output logic [3:0] ccr_out
);

    typedef enum logic [3:0] {
        S0, S1, S2, S3, S4, S5, S6, S7, S8
    } state_t;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BEQ     = 8'h23;

    state_t     r_state;
    logic [7:0] r_pc, r_ir, r_mar, r_a, r_b, r_to_memory;
    logic [3:0] r_ccr;
    logic       r_write;

    logic [8:0] w_sum, w_diff;
    logic       w_add_v, w_sub_v;

    // Bit 8 of the 9-bit difference is the unsigned borrow.
    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_add_v = (r_a[7] == r_b[7]) && (w_sum[7]  != r_a[7]);
    assign w_sub_v = (r_a[7] != r_b[7]) && (w_diff[7] != r_a[7]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S0;
            r_pc        <= 8'h00;
            r_ir        <= 8'h00;
            r_mar       <= 8'h00;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_ccr       <= 4'b0000;
            r_write     <= 1'b0;
            r_to_memory <= 8'h00;
        end else begin
            r_write     <= 1'b0;
            r_to_memory <= 8'h00;
            case (r_state)
                S0: begin r_mar <= r_pc;          r_state <= S1; end
                S1: begin r_pc  <= r_pc + 8'd1;   r_state <= S2; end
                S2: begin r_ir  <= from_memory;   r_state <= S3; end
                S3: begin
                    case (r_ir)
                        OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
                        OP_STA_DIR, OP_STB_DIR, OP_ADD_AB, OP_SUB_AB,
                        OP_BRA, OP_BEQ: r_state <= S4;
                        default:        r_state <= S0;
                    endcase
                end
                S4: begin
                    r_state <= S0;
                    case (r_ir)
                        OP_ADD_AB: begin
                            r_a   <= w_sum[7:0];
                            r_ccr <= {w_sum[7], (w_sum[7:0] == 8'h00), w_add_v, w_sum[8]};
                        end
                        OP_SUB_AB: begin
                            r_a   <= w_diff[7:0];
                            r_ccr <= {w_diff[7], (w_diff[7:0] == 8'h00), w_sub_v, w_diff[8]};
                        end
                        OP_BEQ: begin
                            if (r_ccr[2]) begin
                                r_mar   <= r_pc;
                                r_state <= S5;
                            end else begin
                                r_pc <= r_pc + 8'd1;
                            end
                        end
                        default: begin
                            r_mar   <= r_pc;
                            r_state <= S5;
                        end
                    endcase
                end
                S5: begin
                    // Branches only wait here for the operand read.
                    if (r_ir != OP_BRA && r_ir != OP_BEQ)
                        r_pc <= r_pc + 8'd1;
                    r_state <= S6;
                end
                S6: begin
                    r_state <= S0;
                    case (r_ir)
                        OP_LDA_IMM: begin
                            r_a   <= from_memory;
                            r_ccr <= {from_memory[7], (from_memory == 8'h00), r_ccr[1:0]};
                        end
                        OP_LDB_IMM: begin
                            r_b   <= from_memory;
                            r_ccr <= {from_memory[7], (from_memory == 8'h00), r_ccr[1:0]};
                        end
                        OP_LDA_DIR, OP_LDB_DIR: begin
                            r_mar   <= from_memory;
                            r_state <= S7;
                        end
                        OP_STA_DIR, OP_STB_DIR: begin
                            r_mar       <= from_memory;
                            r_write     <= 1'b1;
                            r_to_memory <= (r_ir == OP_STA_DIR) ? r_a : r_b;
                            r_state     <= S7;
                        end
                        default: r_pc <= from_memory;
                    endcase
                end
                S7: begin
                    if (r_ir == OP_LDA_DIR || r_ir == OP_LDB_DIR)
                        r_state <= S8;
                    else
                        r_state <= S0;
                end
                S8: begin
                    if (r_ir == OP_LDA_DIR)
                        r_a <= from_memory;
                    else
                        r_b <= from_memory;
                    r_ccr   <= {from_memory[7], (from_memory == 8'h00), r_ccr[1:0]};
                    r_state <= S0;
                end
                default: r_state <= S0;
            endcase
        end
    end

    assign address   = r_mar;
    assign to_memory = r_to_memory;
    assign write     = r_write;
    assign pc_out    = r_pc;
    assign a_out     = r_a;
    assign ccr_out   = r_ccr;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: synchronous memory model plus an instruction-level
// reference CPU that predicts cycle counts, store strobes and register state.
module tb_cpu_core;

    logic       clock;
    logic       reset;
    logic [7:0] from_memory;
    logic [7:0] address;
    logic [7:0] to_memory;
    logic       write;
    logic [7:0] pc_out;
    logic [7:0] a_out;
    logic [3:0] ccr_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem      [256];
    logic [7:0] prog     [256];
    logic [7:0] ref_mem  [256];
    logic       load_pulse;

    logic [7:0] m_pc, m_a, m_b;
    logic [3:0] m_ccr;

    cpu_core dut (
        .clock(clock), .reset(reset), .from_memory(from_memory),
        .address(address), .to_memory(to_memory), .write(write),
        .pc_out(pc_out), .a_out(a_out), .ccr_out(ccr_out)
    );

    // clock/reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous RAM: read data appears the cycle after the address.
    initial from_memory = 8'h00;
    always @(posedge clock) begin
        if (load_pulse) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else if (write) begin
            mem[address] <= to_memory;
        end
        from_memory <= mem[address];
    end

    // ---------------- driver tasks ----------------
    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h01;
    endtask

    task automatic start_prog();
        @(negedge clock);
        reset      = 1'b0;
        load_pulse = 1'b1;
        @(posedge clock);
        @(negedge clock);
        load_pulse = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = prog[i];
        m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_ccr = 4'b0000;
        reset = 1'b1;
        #1;
    endtask

    task automatic set_nz(input logic [7:0] v);
        m_ccr[3] = v[7];
        m_ccr[2] = (v == 8'h00);
    endtask

    // Reference model advances one instruction, then the DUT is stepped
    // the predicted number of cycles and compared each cycle.
    task automatic run_instr();
        logic [7:0] op, opd, pc0, wr_adr, wr_dat, res;
        int n, wr_cyc, us, ss;
        pc0 = m_pc;
        op = ref_mem[m_pc];
        m_pc = m_pc + 8'd1;
        wr_cyc = -1; wr_adr = 8'h00; wr_dat = 8'h00;
        case (op)
            8'h86, 8'h88: begin
                opd = ref_mem[m_pc]; m_pc = m_pc + 8'd1;
                if (op == 8'h86) m_a = opd; else m_b = opd;
                set_nz(opd); n = 7;
            end
            8'h87, 8'h89: begin
                opd = ref_mem[ref_mem[m_pc]]; m_pc = m_pc + 8'd1;
                if (op == 8'h87) m_a = opd; else m_b = opd;
                set_nz(opd); n = 9;
            end
            8'h96, 8'h97: begin
                wr_adr = ref_mem[m_pc]; m_pc = m_pc + 8'd1;
                wr_dat = (op == 8'h96) ? m_a : m_b;
                wr_cyc = 7; n = 8;
            end
            8'h42, 8'h43: begin
                if (op == 8'h42) begin
                    us = int'(m_a) + int'(m_b);
                    ss = int'($signed(m_a)) + int'($signed(m_b));
                    m_ccr[0] = (us > 255);
                end else begin
                    us = int'(m_a) - int'(m_b);
                    ss = int'($signed(m_a)) - int'($signed(m_b));
                    m_ccr[0] = (m_a < m_b);
                end
                res = 8'(us);
                m_ccr[1] = (ss > 127) || (ss < -128);
                m_a = res; set_nz(res); n = 5;
            end
            8'h20: begin m_pc = ref_mem[m_pc]; n = 7; end
            8'h23: begin
                if (m_ccr[2]) begin m_pc = ref_mem[m_pc]; n = 7; end
                else begin m_pc = m_pc + 8'd1; n = 5; end
            end
            default: n = 4;
        endcase
        for (int c = 0; c < n; c++) begin
            n_checks++;
            if (c == wr_cyc) begin
                if (write !== 1'b1 || address !== wr_adr || to_memory !== wr_dat) begin
                    n_errors++;
                    $display("FAIL store_strobe op=%02h got w=%b a=%02h d=%02h exp w=1 a=%02h d=%02h",
                             op, write, address, to_memory, wr_adr, wr_dat);
                end
            end else if (write !== 1'b0 || to_memory !== 8'h00) begin
                n_errors++;
                $display("FAIL idle_write op=%02h cyc=%0d got w=%b d=%02h exp w=0 d=00",
                         op, c, write, to_memory);
            end
            if (c == 1) begin
                n_checks++;
                if (address !== pc0) begin
                    n_errors++;
                    $display("FAIL fetch_addr op=%02h got %02h exp %02h", op, address, pc0);
                end
            end
            @(posedge clock);
            @(negedge clock);
            #1;
        end
        if (wr_cyc >= 0) ref_mem[wr_adr] = wr_dat;
        n_checks++;
        if (pc_out !== m_pc || a_out !== m_a || ccr_out !== m_ccr) begin
            n_errors++;
            $display("FAIL instr_state op=%02h got pc=%02h a=%02h ccr=%b exp pc=%02h a=%02h ccr=%b",
                     op, pc_out, a_out, ccr_out, m_pc, m_a, m_ccr);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_prog();
        prog[0] = 8'h86; prog[1] = 8'hAA;
        start_prog();
        for (int i = 0; i < 6; i++) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 8'h00 || a_out !== 8'h00 || ccr_out !== 4'b0000 ||
            address !== 8'h00 || write !== 1'b0 || to_memory !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset got pc=%02h a=%02h ccr=%b addr=%02h w=%b d=%02h exp all zero",
                     pc_out, a_out, ccr_out, address, write, to_memory);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_load_store();
        clear_prog();
        prog[0] = 8'h86; prog[1] = 8'hAA; prog[2] = 8'h96; prog[3] = 8'hE0;
        start_prog();
        run_instr();
        n_checks++;
        if (a_out !== 8'hAA || ccr_out !== 4'b1000) begin
            n_errors++;
            $display("FAIL lda_imm got a=%02h ccr=%b exp a=AA ccr=1000", a_out, ccr_out);
        end
        run_instr();
        n_checks++;
        if (mem[8'hE0] !== 8'hAA) begin
            n_errors++;
            $display("FAIL sta_commit got %02h exp AA", mem[8'hE0]);
        end
    endtask

    task automatic test_add_sub();
        logic [7:0] p [13];
        p = '{8'h86, 8'h7F, 8'h88, 8'h01, 8'h42, 8'h88, 8'h80, 8'h42,
              8'h86, 8'h05, 8'h88, 8'h06, 8'h43};
        clear_prog();
        for (int i = 0; i < 13; i++) prog[i] = p[i];
        start_prog();
        run_instr(); run_instr(); run_instr();
        n_checks++;
        if (a_out !== 8'h80 || ccr_out !== 4'b1010) begin
            n_errors++;
            $display("FAIL add_overflow got a=%02h ccr=%b exp a=80 ccr=1010", a_out, ccr_out);
        end
        run_instr(); run_instr();
        n_checks++;
        if (a_out !== 8'h00 || ccr_out !== 4'b0111) begin
            n_errors++;
            $display("FAIL add_carry_zero got a=%02h ccr=%b exp a=00 ccr=0111", a_out, ccr_out);
        end
        run_instr(); run_instr(); run_instr();
        n_checks++;
        if (a_out !== 8'hFF || ccr_out !== 4'b1001) begin
            n_errors++;
            $display("FAIL sub_borrow got a=%02h ccr=%b exp a=FF ccr=1001", a_out, ccr_out);
        end
    endtask

    task automatic test_branch();
        clear_prog();
        prog[0] = 8'h86; prog[1] = 8'h05; prog[2] = 8'h23; prog[3] = 8'h10;
        prog[4] = 8'h86; prog[5] = 8'h00; prog[6] = 8'h23; prog[7] = 8'h10;
        prog[8'h10] = 8'h20; prog[8'h11] = 8'h00;
        start_prog();
        run_instr(); run_instr();
        n_checks++;
        if (pc_out !== 8'h04) begin
            n_errors++;
            $display("FAIL beq_not_taken got pc=%02h exp 04", pc_out);
        end
        run_instr(); run_instr();
        n_checks++;
        if (pc_out !== 8'h10) begin
            n_errors++;
            $display("FAIL beq_taken got pc=%02h exp 10", pc_out);
        end
        run_instr();
        n_checks++;
        if (pc_out !== 8'h00) begin
            n_errors++;
            $display("FAIL bra_loop got pc=%02h exp 00", pc_out);
        end
    endtask

    task automatic test_direct_and_nop();
        clear_prog();
        prog[0] = 8'h88; prog[1] = 8'h81; prog[2] = 8'h87; prog[3] = 8'hF0;
        prog[4] = 8'hFF; prog[8'hF0] = 8'h3C;
        start_prog();
        run_instr(); run_instr();
        n_checks++;
        if (a_out !== 8'h3C || ccr_out !== 4'b0000) begin
            n_errors++;
            $display("FAIL lda_dir got a=%02h ccr=%b exp a=3C ccr=0000", a_out, ccr_out);
        end
        run_instr();
        n_checks++;
        if (a_out !== 8'h3C || ccr_out !== 4'b0000 || pc_out !== 8'h05) begin
            n_errors++;
            $display("FAIL nop got a=%02h ccr=%b pc=%02h exp a=3C ccr=0000 pc=05",
                     a_out, ccr_out, pc_out);
        end
    endtask

    task automatic test_reset_in_store();
        clear_prog();
        prog[0] = 8'h86; prog[1] = 8'h55; prog[2] = 8'h96; prog[3] = 8'hE0;
        prog[8'hE0] = 8'h11;
        start_prog();
        run_instr();
        for (int i = 0; i < 7; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        #1;
        n_checks++;
        if (write !== 1'b1) begin
            n_errors++;
            $display("FAIL store_s7_reached got w=%b exp 1", write);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (write !== 1'b0 || to_memory !== 8'h00 || address !== 8'h00) begin
            n_errors++;
            $display("FAIL store_abort got w=%b d=%02h a=%02h exp w=0 d=00 a=00",
                     write, to_memory, address);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem[8'hE0] !== 8'h11) begin
            n_errors++;
            $display("FAIL store_abort_mem got %02h exp 11", mem[8'hE0]);
        end
        m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_ccr = 4'b0000;
        run_instr();
    endtask

    task automatic test_random();
        logic [7:0] ops [10];
        ops = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h20, 8'h23};
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) prog[i] = 8'($urandom_range(0, 255));
            else prog[i] = ops[$urandom_range(0, 9)];
        end
        start_prog();
        for (int k = 0; k < 250; k++) run_instr();
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (mem[i] !== ref_mem[i]) begin
                n_errors++;
                $display("FAIL random_mem addr=%02h got %02h exp %02h", i[7:0], mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_pulse = 1'b0;
        clear_prog();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h01;
        m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_ccr = 4'b0000;
        test_reset();
        test_load_store();
        test_add_sub();
        test_branch();
        test_direct_and_nop();
        test_reset_in_store();
        for (int r = 0; r < 3; r++) test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
